mem_line_responder: RTL and testbench

- Memory-side responder for the cache controller's line-refill interface.
- Accepts a refill request (req_cc2mem/adr_cc2mem) and returns one cache line as 2^WORD_OFFSET single-word beats on ack_mem2cc/dat_mem2cc.
- Backed by a word-addressed on-chip array that is loaded through a backdoor write port.
- Serves as the synthesizable main-memory end for cache bring-up and integration benches.

---
 rtl/mem_if_pkg.sv | 18 +
 rtl/mem_line_array.sv | 32 +++
 rtl/mem_line_responder.sv | 134 +++++++++++++
 tb/tb_mem_line_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory line refill interface:
// default widths, line geometry and the responder FSM state encoding.
package mem_if_pkg;

  localparam int ADR_WIDTH_DEF   = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int WORD_OFFSET_DEF = 2;
  localparam int WORDS_PER_LINE  = 1 << WORD_OFFSET_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_GAPW,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_line_array.sv
// Word-addressed backing RAM: one synchronous write port, one registered read port.
// A read and write to the same word on the same edge returns the old contents.
module mem_line_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [MEM_AW-1:0]     i_wadr,
  input  logic [DATA_WIDTH-1:0] i_wdat,
  input  logic                  i_re,
  input  logic [MEM_AW-1:0]     i_radr,
  output logic [DATA_WIDTH-1:0] o_rdat
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_AW)-1];
  logic [DATA_WIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wadr] <= i_wdat;
  end

  // Only the read register is reset so the data output clears with the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdat <= '0;
    else if (i_re) r_rdat <= r_mem[i_radr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line refill responder: returns one cache line as single-word beats.
// Define MEM_LINE_RESP_CWF_EN for critical-word-first order; otherwise beats run from word 0.
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int ADR_WIDTH   = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WORD_OFFSET = WORD_OFFSET_DEF,
  parameter int MEM_AW      = 10,
  parameter int LATENCY     = 3,
  parameter int GAP         = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2cc,
  output logic                   busy,
  input  logic                   bd_we,
  input  logic [MEM_AW-1:0]      bd_adr,
  input  logic [DATA_WIDTH-1:0]  bd_dat
);

  localparam int WORDS   = 1 << WORD_OFFSET;
  localparam int LINE_AW = MEM_AW - WORD_OFFSET;
  localparam int CNT_MAX = (LATENCY > GAP) ? LATENCY : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     LAT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam logic [WORD_OFFSET:0] BEATS_LAST = (WORD_OFFSET+1)'(WORDS);

  mem_state_e             r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [LINE_AW-1:0]     r_base;
  logic [WORD_OFFSET-1:0] r_word;
  logic [WORD_OFFSET-1:0] r_word_out;
  logic [WORD_OFFSET:0]   r_beats;
  logic                   r_ack;
  logic                   w_accept;
  logic                   w_enter_beat;
  logic [MEM_AW-1:0]      w_idx;
  logic [MEM_AW-1:0]      w_radr;
  logic [WORD_OFFSET-1:0] w_start;
  logic                   w_unused;

  assign w_idx = adr_cc2mem[MEM_AW+1:2];

`ifdef MEM_LINE_RESP_CWF_EN
  assign w_start = w_idx[WORD_OFFSET-1:0];
`else
  assign w_start = '0;
`endif

  // Upper address bits alias; byte offset is meaningless for word beats.
  assign w_unused = &{1'b0, adr_cc2mem[ADR_WIDTH-1:MEM_AW+2], adr_cc2mem[1:0],
                      w_idx[WORD_OFFSET-1:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_cc2mem) w_next = ST_WAIT;
      ST_WAIT: begin
        if (!req_cc2mem)       w_next = ST_IDLE;
        else if (r_cnt == '0)  w_next = ST_BEAT;
      end
      ST_BEAT: begin
        if (!req_cc2mem)                 w_next = ST_IDLE;
        else if (r_beats == BEATS_LAST)  w_next = ST_DONE;
        else if (GAP == 0)               w_next = ST_BEAT;
        else                             w_next = ST_GAPW;
      end
      ST_GAPW: begin
        if (!req_cc2mem)       w_next = ST_IDLE;
        else if (r_cnt == '0)  w_next = ST_BEAT;
      end
      ST_DONE: if (!req_cc2mem) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    w_accept     = (r_state == ST_IDLE) && (w_next == ST_WAIT);
    w_enter_beat = (w_next == ST_BEAT);
  end

  // The array read is issued on the edge entering BEAT, so ack and data align.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_word     <= '0;
      r_beats    <= '0;
      r_ack      <= 1'b0;
      r_word_out <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_enter_beat;
      if (w_accept) begin
        r_cnt   <= LAT_LOAD;
        r_base  <= w_idx[MEM_AW-1:WORD_OFFSET];
        r_word  <= w_start;
        r_beats <= '0;
      end else if (w_enter_beat) begin
        r_cnt      <= GAP_LOAD;
        r_word     <= r_word + 1'b1;
        r_beats    <= r_beats + 1'b1;
        r_word_out <= r_word;
      end else if ((r_state == ST_WAIT || r_state == ST_GAPW) && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_radr = {r_base, r_word};

  mem_line_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .i_we  (bd_we),
    .i_wadr(bd_adr),
    .i_wdat(bd_dat),
    .i_re  (w_enter_beat),
    .i_radr(w_radr),
    .o_rdat(dat_mem2cc)
  );

  assign ack_mem2cc  = r_ack;
  assign word_mem2cc = r_word_out;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed refill scenarios plus randomized
// lines, compared against a cycle-schedule and word-order model of the line protocol.
module tb_mem_line_responder;
  import mem_if_pkg::*;

  localparam int LAT      = 3;
  localparam int GAP      = 1;
  localparam int MEM_AW   = 10;
  localparam int WORDS    = WORDS_PER_LINE;
  localparam int LAST_ACK = LAT + (WORDS - 1) * (GAP + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] dat;
  logic [1:0]  word;
  logic        busy;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_adr = '0;
  logic [31:0] bd_dat = '0;

  logic [31:0] mem_model [0:(1<<MEM_AW)-1];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_line_responder #(
    .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2),
    .MEM_AW(MEM_AW), .LATENCY(LAT), .GAP(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_cc2mem (req),
    .adr_cc2mem (adr),
    .ack_mem2cc (ack),
    .dat_mem2cc (dat),
    .word_mem2cc(word),
    .busy       (busy),
    .bd_we      (bd_we),
    .bd_adr     (bd_adr),
    .bd_dat     (bd_dat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller is at a negedge with the DUT idle. Request is raised now, accepted on the
  // next rising edge (cycle 0), and dropped at the negedge of cycle drop_c.
  // bd_word >= 0 writes bd_val to that word during the cycle its beat is presented.
  task automatic run_line(input logic [31:0] a, input int drop_c, input int bd_word,
                          input logic [31:0] bd_val);
    int   base, start, k, idx;
    logic exp_ack;
`ifdef MEM_LINE_RESP_CWF_EN
    start = int'(a[3:2]);
`else
    start = 0;
`endif
    base = int'(a[11:2]) & ~(WORDS - 1);
    req  = 1'b1;
    adr  = a;
    for (int c = 0; c <= drop_c + 1; c++) begin
      @(negedge clk);
      bd_we = 1'b0;
      if (c == 0) adr = $urandom;
      exp_ack = (c <= drop_c) && (c >= LAT) && (((c - LAT) % (GAP + 1)) == 0) &&
                (((c - LAT) / (GAP + 1)) < WORDS);
      check("ack", ack, exp_ack);
      check("busy", busy, (c <= drop_c));
      if (exp_ack) begin
        k   = (c - LAT) / (GAP + 1);
        idx = base + ((start + k) % WORDS);
        check("data", dat, mem_model[idx]);
        check("word", word, (start + k) % WORDS);
        if (idx == bd_word) begin
          bd_we  = 1'b1;
          bd_adr = idx[9:0];
          bd_dat = bd_val;
          mem_model[idx] = bd_val;
        end
      end
      if (c == drop_c) req = 1'b0;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, v;
    int drop, bw, idle;

    @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dat", dat, 32'h0);
    check("rst_word", word, 2'd0);

    for (int k = 0; k < (1 << MEM_AW); k++) begin
      bd_we  = 1'b1;
      bd_adr = k[9:0];
      bd_dat = 32'h1000_0000 + k;
      mem_model[k] = 32'h1000_0000 + k;
      @(negedge clk);
    end
    bd_we = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // Held 3 cycles past the last beat, then an immediate new line after the drop.
    run_line(32'hFF07_BD08, LAST_ACK + 3, -1, 32'h0);
    run_line(32'hA555_2D0C, LAST_ACK, -1, 32'h0);
    // Abort after the second beat, then a normal line.
    run_line(32'hFF07_BD08, LAT + (GAP + 1), -1, 32'h0);
    run_line(32'h0000_1234, LAST_ACK + 1, -1, 32'h0);
    // Same-cycle backdoor write to a word being returned, then reread it.
    run_line(32'hFF07_BD08, LAST_ACK, 32'h343, 32'hDEAD_BEEF);
    run_line(32'hFF07_BD08, LAST_ACK, -1, 32'h0);
    check("bd_word", mem_model[32'h343], 32'hDEAD_BEEF);

    // Reset during the gap after the first beat.
    req = 1'b1;
    adr = 32'h0000_0D08;
    repeat (LAT + 2) @(negedge clk);
    check("pre_rst_ack", ack, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    req = 1'b0;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dat", dat, 32'h0);
    check("mid_rst_word", word, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_rst_ack", ack, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    run_line(32'h0000_0D08, LAST_ACK, -1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) drop = LAST_ACK + $urandom_range(0, 3);
      else drop = $urandom_range(0, LAST_ACK - 1);
      bw = ($urandom_range(0, 3) == 0) ? int'(a[11:2]) : -1;
      v  = $urandom;
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        check("idle_ack", ack, 1'b0);
        @(negedge clk);
      end
      run_line(a, drop, bw, v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
